// File: rtl/cylon_rx_checker_pkg.sv
// Shared types and constants for the cylon LED bus receive checker.
package cylon_pkg;

  localparam int              CYLON_LED_W  = 8;
  localparam logic [7:0]      CYLON_ALL_ON = 8'hFF;
  localparam int              CYLON_STEPS  = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } cylon_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cylon_rx_checker_if.sv
// LED bus and monitor status bundle; master drives the LEDs, slave is the checker.
interface cylon_rx_checker_if
  import cylon_pkg::*;
#(
  parameter int MXDWELL = 24
);
  logic [CYLON_LED_W-1:0] leds;
  logic [2:0]             pos;
  logic                   dir;
  logic                   all_on;
  logic                   locked;
  logic                   step;
  logic                   err;
  logic [7:0]             err_cnt;
  logic [MXDWELL-1:0]     dwell;
  logic                   stall;

  modport master (
    output leds,
    input  pos, dir, all_on, locked, step, err, err_cnt, dwell, stall
  );

  modport slave (
    input  leds,
    output pos, dir, all_on, locked, step, err, err_cnt, dwell, stall
  );
endinterface

// File: rtl/cylon_rx_checker_onehot_dec.sv
// Combinational 8->3 eye decoder with one-hot / all-on / illegal classification.
module cylon_onehot_dec
  import cylon_pkg::*;
(
  input  logic [CYLON_LED_W-1:0] pat_i,
  output logic [2:0]             pos_o,
  output logic                   onehot_o,
  output logic                   all_on_o,
  output logic                   illegal_o
);

  // Decode pattern class and eye index
  always_comb begin
    pos_o    = 3'd0;
    onehot_o = 1'b1;
    case (pat_i)
      8'h01:   pos_o = 3'd0;
      8'h02:   pos_o = 3'd1;
      8'h04:   pos_o = 3'd2;
      8'h08:   pos_o = 3'd3;
      8'h10:   pos_o = 3'd4;
      8'h20:   pos_o = 3'd5;
      8'h40:   pos_o = 3'd6;
      8'h80:   pos_o = 3'd7;
      default: onehot_o = 1'b0;
    endcase
    all_on_o  = (pat_i == CYLON_ALL_ON);
    illegal_o = !onehot_o && !all_on_o;
  end

endmodule

// File: rtl/cylon_rx_checker.sv
// Cylon LED bus receive checker: two-stage pipeline, sequence FSM, dwell and error counters.
// Optional stall timeout in LOCKED enabled by defining CYLON_RX_STALL_EN.
module cylon_rx_checker
  import cylon_pkg::*;
#(
  parameter int MXDWELL    = 24,
  parameter int LOCK_STEPS = 4
)
(
  input  logic               clock,
  input  logic               reset_n,
  cylon_rx_checker_if.slave  bus
);

  localparam logic [MXDWELL-1:0] DW_ZERO  = {MXDWELL{1'b0}};
  localparam logic [MXDWELL-1:0] DW_ONE   = {{(MXDWELL-1){1'b0}}, 1'b1};
  localparam logic [MXDWELL-1:0] DW_MAX   = {MXDWELL{1'b1}};
  localparam logic [3:0]         LOCK_CNT = 4'(LOCK_STEPS);

  logic [CYLON_LED_W-1:0] pat_q, pat_prev_q;
  cylon_state_e           state_q, state_d;
  logic [2:0]             pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   dk_q, dk_d;
  logic [3:0]             good_q, good_d;
  logic                   all_on_q, locked_q;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [MXDWELL-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic [MXDWELL-1:0]     dwell_q, dwell_d;

  logic                   chg_s, adj_s, err_hit_s, exp_dir_s;
  logic [2:0]             dec_pos_s, exp_pos_s;
  logic                   dec_onehot_s, dec_all_on_s, dec_illegal_s;
  logic [3:0]             good_inc_s;
`ifdef CYLON_RX_STALL_EN
  logic                   stall_q, stall_d, stall_hit_s;
  assign stall_hit_s = (state_q == ST_LOCKED) && (dwell_cnt_q == DW_MAX);
`endif

  cylon_onehot_dec u_dec (
    .pat_i     (pat_q),
    .pos_o     (dec_pos_s),
    .onehot_o  (dec_onehot_s),
    .all_on_o  (dec_all_on_s),
    .illegal_o (dec_illegal_s)
  );

  assign chg_s      = (pat_q != pat_prev_q);
  assign good_inc_s = good_q + 4'd1;
  assign adj_s      = ({1'b0, dec_pos_s} == ({1'b0, pos_q} + 4'd1)) ||
                      ({1'b0, pos_q} == ({1'b0, dec_pos_s} + 4'd1));

  // Expected next eye position, bouncing at both ends
  always_comb begin
    if (dir_q) begin
      if (pos_q == 3'd7) begin
        exp_pos_s = 3'd6;
        exp_dir_s = 1'b0;
      end else begin
        exp_pos_s = pos_q + 3'd1;
        exp_dir_s = 1'b1;
      end
    end else begin
      if (pos_q == 3'd0) begin
        exp_pos_s = 3'd1;
        exp_dir_s = 1'b1;
      end else begin
        exp_pos_s = pos_q - 3'd1;
        exp_dir_s = 1'b0;
      end
    end
  end

  // Dwell counter runs in every state and is latched on each pattern change
  always_comb begin
    if (chg_s) begin
      dwell_cnt_d = DW_ZERO;
      dwell_d     = (dwell_cnt_q == DW_MAX) ? DW_MAX : dwell_cnt_q + DW_ONE;
    end else begin
      dwell_cnt_d = (dwell_cnt_q == DW_MAX) ? DW_MAX : dwell_cnt_q + DW_ONE;
      dwell_d     = dwell_q;
    end
  end

  // Sequence FSM next-state and event pulses
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    dk_d      = dk_q;
    good_d    = good_q;
    step_d    = 1'b0;
    err_hit_s = 1'b0;
`ifdef CYLON_RX_STALL_EN
    stall_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (chg_s && dec_onehot_s) begin
          state_d = ST_ACQUIRE;
          pos_d   = dec_pos_s;
          good_d  = 4'd0;
          dk_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACQUIRE: begin
        if (!chg_s) begin
          state_d = ST_ACQUIRE;
        end else if (!dec_onehot_s) begin
          state_d = ST_IDLE;
        end else if (adj_s && (!dk_q || (dec_pos_s == exp_pos_s))) begin
          pos_d   = dec_pos_s;
          dir_d   = (dec_pos_s > pos_q);
          dk_d    = 1'b1;
          good_d  = good_inc_s;
          step_d  = 1'b1;
          state_d = (good_inc_s == LOCK_CNT) ? ST_LOCKED : ST_ACQUIRE;
        end else begin
          pos_d   = dec_pos_s;
          good_d  = 4'd0;
          dk_d    = 1'b0;
        end
      end
      ST_LOCKED: begin
`ifdef CYLON_RX_STALL_EN
        if (stall_hit_s) begin
          stall_d   = 1'b1;
          err_hit_s = 1'b1;
          state_d   = ST_IDLE;
        end else
`endif
        if (!chg_s) begin
          state_d = ST_LOCKED;
        end else if (dec_onehot_s && (dec_pos_s == exp_pos_s)) begin
          pos_d  = dec_pos_s;
          dir_d  = exp_dir_s;
          step_d = 1'b1;
        end else if (dec_all_on_s) begin
          state_d = ST_IDLE;
        end else if (dec_illegal_s) begin
          err_hit_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          err_hit_s = 1'b1;
          state_d   = ST_ACQUIRE;
          pos_d     = dec_pos_s;
          good_d    = 4'd0;
          dk_d      = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    err_d     = err_hit_s;
    err_cnt_d = err_hit_s ? sat_inc8(err_cnt_q) : err_cnt_q;
  end

  // Input capture, FSM state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat_q       <= 8'h00;
      pat_prev_q  <= 8'h00;
      state_q     <= ST_IDLE;
      pos_q       <= 3'd0;
      dir_q       <= 1'b0;
      dk_q        <= 1'b0;
      good_q      <= 4'd0;
      all_on_q    <= 1'b0;
      locked_q    <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      dwell_cnt_q <= DW_ZERO;
      dwell_q     <= DW_ZERO;
    end else begin
      pat_q       <= bus.leds;
      pat_prev_q  <= pat_q;
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      dk_q        <= dk_d;
      good_q      <= good_d;
      all_on_q    <= dec_all_on_s;
      locked_q    <= (state_d == ST_LOCKED);
      step_q      <= step_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_q     <= dwell_d;
    end
  end

`ifdef CYLON_RX_STALL_EN
  // Stall pulse register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end
  assign bus.stall = stall_q;
`else
  assign bus.stall = 1'b0;
`endif

  assign bus.pos     = pos_q;
  assign bus.dir     = dir_q;
  assign bus.all_on  = all_on_q;
  assign bus.locked  = locked_q;
  assign bus.step    = step_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.dwell   = dwell_q;

endmodule

// File: tb/tb_cylon_rx_checker.sv
// Directed bench for cylon_rx_checker: bounce table plus saturation, reset and freeze sequences.
module tb_cylon_rx_checker;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  cylon_rx_checker_if #(.MXDWELL(6)) bus();

  cylon_rx_checker #(.MXDWELL(6), .LOCK_STEPS(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] leds;
    logic [2:0] pos;
    logic       dir;
    logic       all_on;
    logic       locked;
    logic       step;
    logic       err;
    logic [7:0] ecnt;
    logic       chk_dw;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [7:0] l, input logic [2:0] p, input logic d, input logic a,
                      input logic lk, input logic s, input logic e, input logic [7:0] c,
                      input logic cd);
    vec_t v;
    v.leds = l; v.pos = p; v.dir = d; v.all_on = a; v.locked = lk;
    v.step = s; v.err = e; v.ecnt = c; v.chk_dw = cd;
    vq.push_back(v);
  endtask

  task automatic drive_hold(input logic [7:0] l, input int n);
    @(negedge clock);
    bus.leds = l;
    repeat (n) @(posedge clock);
  endtask

  logic [7:0] seq [6];
  int n_unlock, n_stall, stall_at, err_with_stall;

  initial begin
    bus.leds = 8'h00;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.pos", 32'(bus.pos), 32'd0);
    chk("rst.dir", 32'(bus.dir), 32'd0);
    chk("rst.all_on", 32'(bus.all_on), 32'd0);
    chk("rst.locked", 32'(bus.locked), 32'd0);
    chk("rst.step", 32'(bus.step), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst.dwell", 32'(bus.dwell), 32'd0);
    chk("rst.stall", 32'(bus.stall), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    //     leds   pos   dir   aon   lck   stp   err   cnt   chkdw
    addv(8'hFF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    addv(8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    addv(8'h02, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h04, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h08, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h10, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h20, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h40, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h80, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h40, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h20, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h10, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h08, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h04, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h02, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h02, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h04, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h08, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    addv(8'h20, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    addv(8'h40, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    addv(8'h80, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    addv(8'h40, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    addv(8'h20, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
    addv(8'h00, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1);
    addv(8'h18, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      bus.leds = vq[i].leds;
      repeat (2) @(posedge clock);
      #1;
      chk($sformatf("v%0d.pos", i), 32'(bus.pos), 32'(vq[i].pos));
      chk($sformatf("v%0d.dir", i), 32'(bus.dir), 32'(vq[i].dir));
      chk($sformatf("v%0d.all_on", i), 32'(bus.all_on), 32'(vq[i].all_on));
      chk($sformatf("v%0d.locked", i), 32'(bus.locked), 32'(vq[i].locked));
      chk($sformatf("v%0d.step", i), 32'(bus.step), 32'(vq[i].step));
      chk($sformatf("v%0d.err", i), 32'(bus.err), 32'(vq[i].err));
      chk($sformatf("v%0d.err_cnt", i), 32'(bus.err_cnt), 32'(vq[i].ecnt));
      chk($sformatf("v%0d.stall", i), 32'(bus.stall), 32'd0);
      if (vq[i].chk_dw) begin
        chk($sformatf("v%0d.dwell", i), 32'(bus.dwell), 32'd16);
      end
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.step_pulse", i), 32'(bus.step), 32'd0);
      chk($sformatf("v%0d.err_pulse", i), 32'(bus.err), 32'd0);
      repeat (13) @(posedge clock);
    end

    // Repeated lock-then-corrupt cycles drive the error counter into saturation
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04;
    seq[3] = 8'h08; seq[4] = 8'h10; seq[5] = 8'h00;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 6; k++) drive_hold(seq[k], 2);
      if (i == 99) begin
        #1;
        chk("sat.cnt_mid", 32'(bus.err_cnt), 32'd102);
      end
    end
    #1;
    chk("sat.cnt_hold", 32'(bus.err_cnt), 32'd255);

    drive_hold(8'h01, 3);
    drive_hold(8'h02, 3);
    drive_hold(8'h04, 3);
    drive_hold(8'h08, 3);
    drive_hold(8'h10, 3);
    #1;
    chk("mid.pre_locked", 32'(bus.locked), 32'd1);
    chk("mid.pre_cnt", 32'(bus.err_cnt), 32'd255);
    @(negedge clock);
    bus.leds = 8'h20;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid.pos", 32'(bus.pos), 32'd0);
    chk("mid.dir", 32'(bus.dir), 32'd0);
    chk("mid.locked", 32'(bus.locked), 32'd0);
    chk("mid.step", 32'(bus.step), 32'd0);
    chk("mid.err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("mid.dwell", 32'(bus.dwell), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("post.pos", 32'(bus.pos), 32'd5);
    chk("post.step", 32'(bus.step), 32'd0);
    chk("post.locked", 32'(bus.locked), 32'd0);
    chk("post.err", 32'(bus.err), 32'd0);
    chk("post.err_cnt", 32'(bus.err_cnt), 32'd0);

    // Relock around pos 5, then freeze the display
    drive_hold(8'h40, 3);
    drive_hold(8'h80, 3);
    drive_hold(8'h40, 3);
    @(negedge clock);
    bus.leds = 8'h20;
    n_unlock = 0; n_stall = 0; stall_at = 0; err_with_stall = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock);
      #1;
      if (c == 2) chk("frz.lock_entry", 32'(bus.locked), 32'd1);
      if (bus.stall) begin
        n_stall++;
        stall_at = c;
        if (bus.err) err_with_stall++;
      end
      if (c >= 2 && !bus.locked && n_stall == 0) n_unlock++;
    end
    chk("frz.early_unlock", 32'(n_unlock), 32'd0);
`ifdef CYLON_RX_STALL_EN
    chk("frz.stall_count", 32'(n_stall), 32'd1);
    chk("frz.stall_cycle", 32'(stall_at), 32'd66);
    chk("frz.stall_err", 32'(err_with_stall), 32'd1);
    chk("frz.end_locked", 32'(bus.locked), 32'd0);
    chk("frz.err_cnt", 32'(bus.err_cnt), 32'd1);
`else
    chk("frz.stall_count", 32'(n_stall), 32'd0);
    chk("frz.end_locked", 32'(bus.locked), 32'd1);
    chk("frz.err_cnt", 32'(bus.err_cnt), 32'd0);
`endif

    @(negedge clock);
    bus.leds = 8'h10;
    repeat (2) @(posedge clock);
    #1;
    chk("thaw.dwell_sat", 32'(bus.dwell), 32'd63);
    chk("thaw.pos", 32'(bus.pos), 32'd4);
`ifdef CYLON_RX_STALL_EN
    chk("thaw.step", 32'(bus.step), 32'd0);
    chk("thaw.locked", 32'(bus.locked), 32'd0);
`else
    chk("thaw.step", 32'(bus.step), 32'd1);
    chk("thaw.locked", 32'(bus.locked), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
